// File: rtl/lfsr_pkg.sv
// Shared definitions for the 5-bit LFSR generator/checker pair.
// The generator and the checker step their state through the same lfsr_step.
package lfsr_pkg;

    localparam int LFSR_W = 5;
    localparam logic [LFSR_W-1:0] LFSR_INIT = 5'b00001;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } chk_state_e;

    // Right shift with feedback cur[0]^cur[2] into the MSB; period 31, zero is illegal.
    function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] cur);
        return {cur[0] ^ cur[2], cur[4:1]};
    endfunction

endpackage

// File: rtl/lfsr_checker_if.sv
// Link between the LFSR source and the checker: data beats in, lock/error status out.
interface lfsr_checker_if #(
    parameter int ERR_W = 16
);
    import lfsr_pkg::*;

    logic              in_valid;
    logic [LFSR_W-1:0] in_data;
    logic              clr_count;
    logic              locked;
    logic              match;
    logic              bit_err;
    logic [ERR_W-1:0]  err_count;

    modport master (
        output in_valid, in_data, clr_count,
        input  locked, match, bit_err, err_count
    );

    modport slave (
        input  in_valid, in_data, clr_count,
        output locked, match, bit_err, err_count
    );

endinterface

// File: rtl/lfsr_checker.sv
// Self-synchronising LFSR sequence checker: hunts for a seed, verifies it,
// then flywheels while locked and counts mismatches in a saturating counter.
module lfsr_checker
    import lfsr_pkg::*;
#(
    parameter int LOCK_COUNT   = 4,
    parameter int UNLOCK_COUNT = 3,
    parameter int ERR_W        = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    lfsr_checker_if.slave        bus
);

    localparam int RUN_W  = $clog2(LOCK_COUNT + 1);
    localparam int MISS_W = $clog2(UNLOCK_COUNT + 1);

    chk_state_e        state_q, state_d;
    logic [LFSR_W-1:0] expected_q, expected_d;
    logic [RUN_W-1:0]  run_cnt_q, run_cnt_d;
    logic [MISS_W-1:0] miss_cnt_q, miss_cnt_d;
    logic [ERR_W-1:0]  err_q, err_d;
    logic              locked_q, locked_d;
    logic              match_q, match_d;
    logic              bit_err_q, bit_err_d;
    logic              hit_s;
    logic              err_inc_s;
    logic [RUN_W-1:0]  run_inc_s;
    logic [MISS_W-1:0] miss_inc_s;

    assign hit_s      = (bus.in_data == expected_q);
    assign run_inc_s  = run_cnt_q + 1'b1;
    assign miss_inc_s = miss_cnt_q + 1'b1;

    // Next-state, predictor and status-pulse logic
    always_comb begin
        state_d    = state_q;
        expected_d = expected_q;
        run_cnt_d  = run_cnt_q;
        miss_cnt_d = miss_cnt_q;
        match_d    = 1'b0;
        bit_err_d  = 1'b0;
        err_inc_s  = 1'b0;
        if (bus.in_valid) begin
            case (state_q)
                HUNT: begin
                    if (bus.in_data != {LFSR_W{1'b0}}) begin
                        expected_d = lfsr_step(bus.in_data);
                        run_cnt_d  = {RUN_W{1'b0}};
                        state_d    = VERIFY;
                    end else begin
                        state_d = HUNT;
                    end
                end
                VERIFY: begin
                    if (hit_s) begin
                        match_d    = 1'b1;
                        expected_d = lfsr_step(expected_q);
                        run_cnt_d  = run_inc_s;
                        if (run_inc_s == RUN_W'(LOCK_COUNT)) begin
                            state_d    = LOCKED;
                            miss_cnt_d = {MISS_W{1'b0}};
                        end else begin
                            state_d = VERIFY;
                        end
                    end else if (bus.in_data != {LFSR_W{1'b0}}) begin
                        expected_d = lfsr_step(bus.in_data);
                        run_cnt_d  = {RUN_W{1'b0}};
                    end else begin
                        state_d = HUNT;
                    end
                end
                LOCKED: begin
                    // Flywheel: the predictor keeps stepping whether or not the beat matched
                    expected_d = lfsr_step(expected_q);
                    if (hit_s) begin
                        match_d    = 1'b1;
                        miss_cnt_d = {MISS_W{1'b0}};
                    end else begin
                        bit_err_d  = 1'b1;
                        err_inc_s  = 1'b1;
                        miss_cnt_d = miss_inc_s;
                        if (miss_inc_s == MISS_W'(UNLOCK_COUNT)) begin
                            state_d = HUNT;
                        end else begin
                            state_d = LOCKED;
                        end
                    end
                end
                default: begin
                    state_d = HUNT;
                end
            endcase
        end else begin
            state_d = state_q;
        end

        if (bus.clr_count) begin
            err_d = {ERR_W{1'b0}};
        end else if (err_inc_s && (err_q != {ERR_W{1'b1}})) begin
            err_d = err_q + 1'b1;
        end else begin
            err_d = err_q;
        end

        locked_d = (state_d == LOCKED);
    end

    // State and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= HUNT;
            expected_q <= {LFSR_W{1'b0}};
            run_cnt_q  <= {RUN_W{1'b0}};
            miss_cnt_q <= {MISS_W{1'b0}};
            err_q      <= {ERR_W{1'b0}};
            locked_q   <= 1'b0;
            match_q    <= 1'b0;
            bit_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            expected_q <= expected_d;
            run_cnt_q  <= run_cnt_d;
            miss_cnt_q <= miss_cnt_d;
            err_q      <= err_d;
            locked_q   <= locked_d;
            match_q    <= match_d;
            bit_err_q  <= bit_err_d;
        end
    end

    assign bus.locked    = locked_q;
    assign bus.match     = match_q;
    assign bus.bit_err   = bit_err_q;
    assign bus.err_count = err_q;

endmodule

// File: tb/tb_lfsr_checker.sv
// Directed bench for lfsr_checker: default-parameter instance plus a narrow
// saturating-counter instance (ERR_W=2, UNLOCK_COUNT=8) fed the same stimulus.
module tb_lfsr_checker;

    logic clk;
    logic reset;
    int   total;
    int   bad;

    lfsr_checker_if #(.ERR_W(16)) ifa ();
    lfsr_checker_if #(.ERR_W(2))  ifb ();

    lfsr_checker #(.LOCK_COUNT(4), .UNLOCK_COUNT(3), .ERR_W(16)) dut_a (
        .clk(clk), .reset(reset), .bus(ifa.slave)
    );
    lfsr_checker #(.LOCK_COUNT(4), .UNLOCK_COUNT(8), .ERR_W(2)) dut_b (
        .clk(clk), .reset(reset), .bus(ifb.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference sequence from seed 00001
    logic [4:0] seq [0:6];
    initial begin
        seq[0] = 5'b00001; seq[1] = 5'b10000; seq[2] = 5'b01000; seq[3] = 5'b00100;
        seq[4] = 5'b10010; seq[5] = 5'b01001; seq[6] = 5'b10100;
    end

    task automatic drive(input logic v, input logic [4:0] d, input logic clr);
        @(negedge clk);
        ifa.in_valid = v; ifa.in_data = d; ifa.clr_count = clr;
        ifb.in_valid = v; ifb.in_data = d; ifb.clr_count = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_a(input string name, input logic lk, input logic m, input logic be, input logic [15:0] ec);
        total++;
        if (ifa.locked !== lk || ifa.match !== m || ifa.bit_err !== be || ifa.err_count !== ec) begin
            bad++;
            $display("FAIL %s: got locked=%b match=%b bit_err=%b err=%0d, want locked=%b match=%b bit_err=%b err=%0d",
                     name, ifa.locked, ifa.match, ifa.bit_err, ifa.err_count, lk, m, be, ec);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        ifa.in_valid = 1'b0; ifa.in_data = 5'b00000; ifa.clr_count = 1'b0;
        ifb.in_valid = 1'b0; ifb.in_data = 5'b00000; ifb.clr_count = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic lock_up();
        for (int i = 0; i < 5; i++) drive(1'b1, seq[i], 1'b0);
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        chk_a("reset_state", 1'b0, 1'b0, 1'b0, 16'd0);
        total++;
        if (ifb.err_count !== 2'd0 || ifb.locked !== 1'b0) begin
            bad++;
            $display("FAIL reset_b: got locked=%b err=%0d, want 0 0", ifb.locked, ifb.err_count);
        end
    endtask

    task automatic test_lock();
        do_reset();
        drive(1'b1, seq[0], 1'b0);
        chk_a("lock_beat1", 1'b0, 1'b0, 1'b0, 16'd0);
        for (int i = 1; i < 4; i++) begin
            drive(1'b1, seq[i], 1'b0);
            chk_a("lock_verify", 1'b0, 1'b1, 1'b0, 16'd0);
        end
        drive(1'b1, seq[4], 1'b0);
        chk_a("lock_beat5", 1'b1, 1'b1, 1'b0, 16'd0);
        drive(1'b0, 5'b00000, 1'b0);
        chk_a("lock_idle", 1'b1, 1'b0, 1'b0, 16'd0);
    endtask

    task automatic test_single_error();
        do_reset();
        lock_up();
        drive(1'b1, 5'b01011, 1'b0);
        chk_a("single_err", 1'b1, 1'b0, 1'b1, 16'd1);
        drive(1'b1, seq[6], 1'b0);
        chk_a("flywheel_match", 1'b1, 1'b1, 1'b0, 16'd1);
    endtask

    task automatic test_loss_of_lock();
        do_reset();
        lock_up();
        drive(1'b1, 5'b00000, 1'b0);
        drive(1'b1, 5'b00000, 1'b0);
        chk_a("loss_miss2", 1'b1, 1'b0, 1'b1, 16'd2);
        drive(1'b1, 5'b00000, 1'b0);
        chk_a("loss_miss3", 1'b0, 1'b0, 1'b1, 16'd3);
        for (int i = 0; i < 4; i++) drive(1'b1, seq[i], 1'b0);
        chk_a("relock_pre", 1'b0, 1'b1, 1'b0, 16'd3);
        drive(1'b1, seq[4], 1'b0);
        chk_a("relock", 1'b1, 1'b1, 1'b0, 16'd3);
    endtask

    task automatic test_gaps_and_zero();
        do_reset();
        for (int i = 0; i < 3; i++) drive(1'b1, 5'b00000, 1'b0);
        chk_a("zero_hunt", 1'b0, 1'b0, 1'b0, 16'd0);
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, seq[i], 1'b0);
            drive(1'b0, 5'b11111, 1'b0);
            if (i < 4) chk_a("gap_idle", 1'b0, 1'b0, 1'b0, 16'd0);
        end
        chk_a("gap_locked", 1'b1, 1'b0, 1'b0, 16'd0);
        drive(1'b1, seq[5], 1'b0);
        chk_a("gap_after_lock", 1'b1, 1'b1, 1'b0, 16'd0);
    endtask

    task automatic test_saturation();
        logic [1:0] want [0:4];
        want[0] = 2'd1; want[1] = 2'd2; want[2] = 2'd3; want[3] = 2'd3; want[4] = 2'd3;
        do_reset();
        lock_up();
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 5'b00000, 1'b0);
            total++;
            if (ifb.err_count !== want[i] || ifb.locked !== 1'b1 || ifb.bit_err !== 1'b1) begin
                bad++;
                $display("FAIL sat_%0d: got err=%0d locked=%b bit_err=%b, want err=%0d locked=1 bit_err=1",
                         i, ifb.err_count, ifb.locked, ifb.bit_err, want[i]);
            end
        end
        drive(1'b1, 5'b00000, 1'b1);
        total++;
        if (ifb.err_count !== 2'd0 || ifb.bit_err !== 1'b1) begin
            bad++;
            $display("FAIL sat_clear: got err=%0d bit_err=%b, want err=0 bit_err=1", ifb.err_count, ifb.bit_err);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        lock_up();
        drive(1'b1, 5'b01011, 1'b0);
        chk_a("pre_async", 1'b1, 1'b0, 1'b1, 16'd1);
        #2;
        reset = 1'b1;
        #1;
        chk_a("async_reset", 1'b0, 1'b0, 1'b0, 16'd0);
        @(negedge clk);
        reset = 1'b0;
        ifa.in_valid = 1'b0; ifb.in_valid = 1'b0;
        lock_up();
        chk_a("async_relock", 1'b1, 1'b1, 1'b0, 16'd0);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b1;
        ifa.in_valid = 1'b0; ifa.in_data = 5'b00000; ifa.clr_count = 1'b0;
        ifb.in_valid = 1'b0; ifb.in_data = 5'b00000; ifb.clr_count = 1'b0;
        test_reset();
        test_lock();
        test_single_error();
        test_loss_of_lock();
        test_gaps_and_zero();
        test_saturation();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
